// File: rtl/vga_text_pixel_gen.sv
// vga_text_pixel_gen
//   Converts the current pixel position from a VGA timing stage into a text-mode
//   pixel. The screen is an 80x30 grid of 8x16-pixel character cells. Each cell's
//   character code is read from an external character memory, and its glyph row
//   is read from an external font ROM. An optional blinking underline cursor and a
//   per-character inverse flag modify the pixel. Colour, hsync and vsync leave the
//   block exactly 3 clocks after the pixel enters.
//
// Ports
//   clk, rst_n             system clock (rising edge), asynchronous active-low reset
//   pixel_x, pixel_y       current pixel coordinates from the timing stage
//   hs_in, vs_in           active-low syncs from the timing stage
//   blank_in               1 outside the visible area
//   char_addr / char_data  character memory: address out (comb), data back 1 clk later
//                          (data[6:0] = code, data[7] = inverse)
//   font_addr / font_data  font ROM: address out (comb), row bits back 1 clk later
//                          (bit 7 = leftmost pixel)
//   cursor_en, cursor_col, cursor_row   cursor enable and cell position
//   vga_r, vga_g, vga_b    registered 4-bit colour outputs
//   vga_hs, vga_vs         registered active-low syncs
module vga_text_pixel_gen #(
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        blank_in,
  output logic [11:0] char_addr,
  input  logic [7:0]  char_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs
);

  // Selects one glyph pixel; bit 7 of the font row is the leftmost pixel.
  function automatic logic font_pixel(input logic [7:0] row_bits,
                                      input logic [2:0] xsel);
    return row_bits[3'd7 - xsel];
  endfunction

  // Blanked pixels are forced to black regardless of the chosen colours.
  function automatic logic [11:0] colour_sel(input logic blank, input logic pix);
    logic [11:0] c;
    if (blank)    c = 12'h000;
    else if (pix) c = FG_COLOR;
    else          c = BG_COLOR;
    return c;
  endfunction

  // Cell addressing (input side, combinational)
  logic [6:0]  cell_col;
  logic [5:0]  cell_row;
  logic        cursor_in_grid;
  logic        cell_match;
  logic        blink;

  // Stage 1 registers
  logic        hs_p1_q, hs_p1_d;
  logic        vs_p1_q, vs_p1_d;
  logic        blank_p1_q, blank_p1_d;
  logic [3:0]  line_p1_q, line_p1_d;
  logic [2:0]  xsel_p1_q, xsel_p1_d;
  logic        cur_p1_q, cur_p1_d;

  // Stage 2 registers
  logic        hs_p2_q, hs_p2_d;
  logic        vs_p2_q, vs_p2_d;
  logic        blank_p2_q, blank_p2_d;
  logic [3:0]  line_p2_q, line_p2_d;
  logic [2:0]  xsel_p2_q, xsel_p2_d;
  logic        cur_p2_q, cur_p2_d;
  logic        inv_p2_q, inv_p2_d;

  // Stage 3 (output) registers
  logic [11:0] rgb_p3_q, rgb_p3_d;
  logic        hs_p3_q, hs_p3_d;
  logic        vs_p3_q, vs_p3_d;

  // Frame counter for the cursor blink
  logic [5:0]  frame_cnt_q, frame_cnt_d;

  logic        cursor_line;
  logic        pix_bit;

  assign cell_col = pixel_x[9:3];
  assign cell_row = pixel_y[9:4];

  // row*80 = row*64 + row*16; the sum is deliberately kept to 12 bits with no
  // clamping, since out-of-grid rows only occur while blanked.
  assign char_addr = {cell_row, 6'b0} + {2'b0, cell_row, 4'b0} + {5'b0, cell_col};

  // A cursor position outside the 80x30 grid never matches any cell.
  assign cursor_in_grid = (cursor_col < 7'd80) && (cursor_row < 5'd30);
  assign cell_match     = cursor_in_grid && (cursor_col == cell_col) &&
                          ({1'b0, cursor_row} == cell_row);
  assign blink          = frame_cnt_q[5];

  // Frame counter: counts falling edges of vs_in. vs_p1_q is vs_in delayed by one
  // clock, so it doubles as the edge detector's history bit.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (vs_p1_q && !vs_in) frame_cnt_d = frame_cnt_q + 6'd1;
  end

  // ---- stage 1: pixel sampled, character memory read in flight ----
  always_comb begin
    hs_p1_d    = hs_in;
    vs_p1_d    = vs_in;
    blank_p1_d = blank_in;
    line_p1_d  = pixel_y[3:0];
    xsel_p1_d  = pixel_x[2:0];
    cur_p1_d   = cursor_en && blink && cell_match;
  end

  // Character data is valid during stage 1; the glyph row follows the cell line.
  assign font_addr = {char_data[6:0], line_p1_q};

  // ---- stage 2: font ROM read in flight ----
  always_comb begin
    hs_p2_d    = hs_p1_q;
    vs_p2_d    = vs_p1_q;
    blank_p2_d = blank_p1_q;
    line_p2_d  = line_p1_q;
    xsel_p2_d  = xsel_p1_q;
    cur_p2_d   = cur_p1_q;
    inv_p2_d   = char_data[7];
  end

  // ---- stage 3: pixel resolved to colour ----
  // The cursor is an underline on the last two lines of the cell (14 and 15).
  assign cursor_line = cur_p2_q && (line_p2_q[3:1] == 3'b111);
  assign pix_bit     = font_pixel(font_data, xsel_p2_q) ^ inv_p2_q ^ cursor_line;

  always_comb begin
    rgb_p3_d = colour_sel(blank_p2_q, pix_bit);
    hs_p3_d  = hs_p2_q;
    vs_p3_d  = vs_p2_q;
  end

  // Control state: blanks and syncs reset to their inactive levels so the first
  // two clocks after release come out black with syncs high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_p1_q     <= 1'b1;
      vs_p1_q     <= 1'b1;
      blank_p1_q  <= 1'b1;
      hs_p2_q     <= 1'b1;
      vs_p2_q     <= 1'b1;
      blank_p2_q  <= 1'b1;
      rgb_p3_q    <= 12'h000;
      hs_p3_q     <= 1'b1;
      vs_p3_q     <= 1'b1;
      frame_cnt_q <= 6'd0;
    end else begin
      hs_p1_q     <= hs_p1_d;
      vs_p1_q     <= vs_p1_d;
      blank_p1_q  <= blank_p1_d;
      hs_p2_q     <= hs_p2_d;
      vs_p2_q     <= vs_p2_d;
      blank_p2_q  <= blank_p2_d;
      rgb_p3_q    <= rgb_p3_d;
      hs_p3_q     <= hs_p3_d;
      vs_p3_q     <= vs_p3_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Datapath state: masked by the blank bits until valid data has flowed through.
  always_ff @(posedge clk) begin
    line_p1_q <= line_p1_d;
    xsel_p1_q <= xsel_p1_d;
    cur_p1_q  <= cur_p1_d;
    line_p2_q <= line_p2_d;
    xsel_p2_q <= xsel_p2_d;
    cur_p2_q  <= cur_p2_d;
    inv_p2_q  <= inv_p2_d;
  end

  assign vga_r  = rgb_p3_q[11:8];
  assign vga_g  = rgb_p3_q[7:4];
  assign vga_b  = rgb_p3_q[3:0];
  assign vga_hs = hs_p3_q;
  assign vga_vs = vs_p3_q;

endmodule
